// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, special instruction words and fetch states.
package cpu_pkg;

    localparam int unsigned NBITS = 32;
    localparam logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [NBITS-1:0] NOP_WORD  = '0;

    typedef enum logic {
        FS_RUN,
        FS_HALTED
    } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded program survives a CPU reset.
module instr_mem #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned MEM_DEPTH = 256,
    localparam int unsigned ADDR_W   = $clog2(MEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [NBITS-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [NBITS-1:0]  o_rd_data
);

    logic [NBITS-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, redirect/stall/halt control and the instruction RAM.
// Define IFETCH_STEP_EN to add the i_step single-step input for the debug unit.
module instruction_fetch #(
    parameter int unsigned       NBITS     = cpu_pkg::NBITS,
    parameter int unsigned       MEM_DEPTH = 256,
    parameter logic [NBITS-1:0]  HALT_WORD = cpu_pkg::HALT_WORD,
    localparam int unsigned      ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
`ifdef IFETCH_STEP_EN
    input  logic              i_step,
`endif
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [NBITS-1:0]  i_branch_target,
    input  logic              i_jump,
    input  logic [NBITS-1:0]  i_jump_target,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [NBITS-1:0]  i_wr_data,
    output logic [NBITS-1:0]  o_pc,
    output logic [NBITS-1:0]  o_pc_next,
    output logic [NBITS-1:0]  o_instruction,
    output logic              o_halt
);

    import cpu_pkg::*;

    localparam logic [NBITS-1:0] ALIGN_MASK = ~NBITS'(3);

    fetch_state_e      r_state;
    logic [NBITS-1:0]  r_pc;
    logic              r_halt;
    logic [NBITS-1:0]  w_rd_data;
    logic [NBITS-1:0]  w_pc_plus4;
    logic [NBITS-1:0]  w_br_target;
    logic [NBITS-1:0]  w_jmp_target;
    logic              w_advance;

    assign w_pc_plus4   = r_pc + NBITS'(4);
    assign w_br_target  = i_branch_target & ALIGN_MASK;
    assign w_jmp_target = i_jump_target & ALIGN_MASK;

`ifdef IFETCH_STEP_EN
    logic r_step;

    // Step only acts on its rising edge, so a held i_step advances once.
    always_ff @(posedge i_clk) begin
        r_step <= i_step;
    end

    assign w_advance = i_enable || (i_step && !r_step);
`else
    assign w_advance = i_enable;
`endif

    instr_mem #(
        .NBITS     (NBITS),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_instr_mem (
        .i_clk     (i_clk),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (r_pc[ADDR_W+1:2]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc    <= '0;
            r_state <= FS_RUN;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                FS_RUN: begin
                    if (w_advance) begin
                        // Branch is resolved in EX, so it is older than jump and stall.
                        if (i_branch_taken) begin
                            r_pc <= w_br_target;
                        end else if (i_stall) begin
                            r_pc <= r_pc;
                        end else if (i_jump) begin
                            r_pc <= w_jmp_target;
                        end else if (w_rd_data == HALT_WORD) begin
                            r_state <= FS_HALTED;
                            r_halt  <= 1'b1;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                FS_HALTED: begin
                    r_pc <= r_pc;
                end
                default: begin
                    r_state <= FS_RUN;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_next     = w_pc_plus4;
    assign o_halt        = r_halt;
    assign o_instruction = r_halt ? NOP_WORD : w_rd_data;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- First pipeline stage. Holds the program counter and a word-addressed instruction memory.
- Each cycle it presents the instruction at PC and PC+4 to the IF/ID pipeline register.
- Redirects on branch or jump and holds on hazard stall or debug disable.
- Detects the HALT word and parks the front end until reset.

Parameters:
- NBITS, 32, datapath/PC width.
- MEM_DEPTH, 256, instruction memory depth in words (power of 2).
- HALT_WORD, 32'hFFFF_FFFF, encoding that halts fetch.
- ADDR_W (localparam), $clog2(MEM_DEPTH), word index width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  debug-unit run enable; 0 = freeze PC.
- i_stall  in  1  hazard-unit stall (load-use); hold PC.
- i_branch_taken  in  1  EX-stage branch resolved taken.
- i_branch_target  in  NBITS  branch destination address.
- i_jump  in  1  ID-stage jump (J/JAL/JR/JALR).
- i_jump_target  in  NBITS  jump destination address.
- i_wr_en  in  1  loader write strobe.
- i_wr_addr  in  ADDR_W  loader word index.
- i_wr_data  in  NBITS  loader instruction word.
- o_pc  out  NBITS  current PC.
- o_pc_next  out  NBITS  PC+4, to IF/ID (link address).
- o_instruction  out  NBITS  instruction at PC.
- o_halt  out  1  halt reached.

Behaviour:
- States: RUN, HALTED. Reset state is RUN with pc=0 and o_halt=0.
- Instruction memory is not reset: contents survive i_rst.
- Outputs at reset: o_pc=0, o_pc_next=4, o_instruction=mem[0].
- Memory read is asynchronous: o_instruction = mem[pc[ADDR_W+1:2]], valid in the same cycle as PC. IF/ID supplies the pipeline register, so fetch adds zero latency.
- Addressing:
  - PC bits above ADDR_W+1 are ignored (address aliasing).
  - Targets have bits [1:0] forced to 0.
  - pc+4 wraps modulo 2^NBITS.
- Memory write is synchronous. A write to the word currently at PC is visible on o_instruction the next cycle. Writes are accepted in any state.
- PC update priority, evaluated at posedge, RUN state:
  1. i_rst → pc=0, state RUN.
  2. !i_enable → hold.
  3. i_branch_taken → pc = i_branch_target (the branch is the older instruction, so it beats jump and stall).
  4. i_stall → hold.
  5. i_jump → pc = i_jump_target.
  6. o_instruction == HALT_WORD → hold pc, state → HALTED.
  7. Otherwise pc = pc+4.
- HALT handling:
  - The HALT word is presented downstream for exactly the one cycle in which it is detected.
  - Detection is suppressed by a simultaneous branch or jump (wrong-path HALT), by stall, and by !i_enable.
- HALTED state:
  - pc frozen; o_halt=1; o_instruction forced to 0 (NOP) so the pipeline drains.
  - Branch, jump and stall inputs are ignored. Only i_rst leaves HALTED.
- Reset mid-operation (including while HALTED): next cycle pc=0, state RUN, o_halt=0.

Optional Feature:
- Macro IFETCH_STEP_EN.
- When defined: adds port i_step (in, 1). While i_enable=0, a one-cycle i_step pulse performs exactly one fetch update with normal priority. An i_step held high advances only once per rising edge of i_step (edge-detected internally, one register). i_step is ignored when i_enable=1.
- When undefined: port absent; !i_enable always holds.

Decomposition:
- Shared package (cpu_pkg), used by the decoder and debug unit:
  - NBITS.
  - HALT_WORD.
  - NOP_WORD = 0.
  - Fetch state enum {FS_RUN, FS_HALTED}.
- One sub-module: instr_mem, a single-write-port, single async-read-port RAM parameterised by NBITS/MEM_DEPTH. PC/FSM logic stays in instruction_fetch.

Test Plan:
- Load mem[0..3]=A,B,C,D; reset; enable → o_pc 0,4,8,12 on consecutive cycles; o_instruction A,B,C,D; o_pc_next = o_pc+4.
- i_stall=1 for 2 cycles at pc=8 → pc stays 8 and o_instruction=C for both; resumes at 12.
- i_branch_taken=1 (target 0x40) together with i_jump=1 (target 0x80) and i_stall=1 at pc=4 → next pc=0x40. Jump alone, target 0x23 → pc=0x20.
- mem[2]=HALT_WORD → HALT on o_instruction at pc=8 for one cycle, then o_halt=1, o_instruction=0, pc=8 held for 10 cycles despite branch pulses. i_rst → pc=0, o_halt=0.
- PC=4·(MEM_DEPTH-1) then advance → pc=4·MEM_DEPTH, reads mem[0] (alias). PC=0xFFFF_FFFC +4 → 0.
- IFETCH_STEP_EN: i_enable=0, i_step held high 5 cycles → pc advances exactly once. Without the macro, the same sequence with i_enable=0 → pc never moves.
